cordic_phase_detector: RTL and testbench
========================================

# cordic_phase_detector

Pipelined CORDIC vectoring-mode phase/magnitude detector: the inverse of the DDFS rotation-mode CORDIC. It accepts signed cosine/sine (I/Q) sample pairs and returns the instantaneous phase on the same 16-bit phase scale the DDFS consumes (2^16 = 360°). It also returns the raw magnitude and the per-sample phase increment, plus a block-averaged increment. It sits downstream of the DDFS (loopback/self-test) or any I/Q source, for frequency-word recovery and phase measurement.

## Interface
- SAN_CP, 16, input sample width (signed)
- STG, 16, number of CORDIC iteration stages (≤16, atan table length)
- AVG_LOG2, 4, log2 of samples per averaged frequency output
- clock_100_MHz  in  1  system clock, all logic on rising edge
- clear_DDFS  in  1  reset; one clock domain (clock_100_MHz), reset synchronous and active-high
- COSINE_IN  in  SAN_CP  signed I sample
- SINE_IN  in  SAN_CP  signed Q sample
- in_valid  in  1  sample qualifier; one sample per cycle max, no backpressure
- PHASE_OUT  out  16  unsigned phase, 0..65535 ↔ 0..<360°
- MAG_OUT  out  SAN_CP+2  unsigned magnitude × CORDIC gain (≈1.647), uncompensated
- out_valid  out  1  PHASE_OUT/MAG_OUT valid
- FREQ_OUT  out  16  signed phase increment vs previous valid sample, mod 2^16
- freq_valid  out  1  FREQ_OUT valid
- FREQ_AVG  out  16  signed mean of last 2^AVG_LOG2 increments
- avg_valid  out  1  one-cycle pulse per completed average block

## Operation
- Internal X/Y width SAN_CP+2 (headroom for √2·1.647 growth, and for negating −2^(SAN_CP−1)); Z width 16, wraps mod 2^16.
- Pre-rotation (registered): X≥0 → (X,Y,Z0=0). X<0, Y≥0 → (Y,−X,Z0=16384). X<0, Y<0 → (−Y,X,Z0=49152).
- Stage i (0..STG−1), d = (Y≥0): X += d ? Y>>>i : −(Y>>>i); Y −= d ? X>>>i : −(X>>>i); Z += d ? atan[i] : −atan[i]. X/Y updates use the stage-input values.
- Results: PHASE_OUT = final Z; MAG_OUT = final X (non-negative by construction).
- Zero input (I=Q=0): a flag is carried down the pipeline and forces PHASE_OUT=0, MAG_OUT=0.
- Accuracy: |PHASE_OUT error| ≤ 16 LSB for input magnitude ≥ 1024; MAG_OUT within ±0.5% of 1.647·|I+jQ|.
- Frequency: on each out_valid, FREQ_OUT = PHASE_OUT − prev_phase, modulo 2^16 and read as signed. prev_phase is then updated.
- First out_valid after reset only loads prev_phase. freq_valid stays low for that sample and is asserted with out_valid from then on.
- Averager: sums FREQ_OUT (16+AVG_LOG2 bits) over 2^AVG_LOG2 freq_valid samples, counting 0..2^AVG_LOG2−1. On the last sample, FREQ_AVG = (sum incl. current) >>> AVG_LOG2 (arithmetic, floor), avg_valid pulses, and sum/count restart.
- Gaps in in_valid pass bubbles through; prev_phase, sum and count hold across bubbles.

## Timing
- Fully pipelined, throughput 1 sample/cycle.
- Latency: out_valid asserts STG+2 cycles after the in_valid cycle (1 pre-rotation + STG iterations + 1 output register). This is 18 at defaults.
- freq_valid is coincident with out_valid. avg_valid is coincident with the out_valid of the block's last sample.
- Reset values: PHASE_OUT=0, MAG_OUT=0, FREQ_OUT=0, FREQ_AVG=0, all valids 0, prev_phase/sum/count/first-flag cleared.
- clear_DDFS mid-stream: the whole valid pipeline flushes. No out_valid for samples accepted before or during clear. in_valid during clear is ignored. The first sample after clear behaves as post-reset.
- Simultaneous clear and in_valid: clear wins.

## Structure
- Shared package cordic_pkg: PHASE_BITS=16, atan table (16 entries, 2^13 = 45°, identical to DDFS table), quadrant phase constants 0/16384/32768/49152, CORDIC gain constant 1.647.
- Sub-module cordic_vector_stage (parameter SHIFT, ATAN): one registered iteration carrying X, Y, Z, valid and zero flag. It is generated STG times in the top level.

## Test plan
- Reset: hold clear_DDFS 3 cycles → all outputs 0, no valids; release with no in_valid → outputs stay 0.
- Axis points, magnitude 1000: (1000,0)→PHASE 0; (0,1000)→16384; (−1000,0)→32768; (0,−1000)→49152; each ±16 LSB, MAG_OUT 1647±8, out_valid exactly 18 cycles after in_valid.
- Extremes: (−32768,0)→PHASE 32768±16, MAG_OUT ≈53969±270, no overflow; (0,0)→PHASE 0, MAG 0; (23170,23170)→8192±16.
- Rotating phasor, amplitude 16000, step +4096 over >32 samples crossing 65535→0 → FREQ_OUT 4096±16 every sample incl. wrap; first sample freq_valid=0; FREQ_AVG 4096±16 with avg_valid every 16 samples. Repeat with step −4096 → −4096.
- Bursty input (in_valid 1-of-3 cycles) with same phasor → identical FREQ_OUT/FREQ_AVG values, valids aligned with latency 18.
- clear_DDFS pulsed 1 cycle mid-stream with 10 samples in flight → zero out_valid afterward for those samples; next sample after clear has freq_valid=0; the average count restarts at 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC phase detector: phase scale, arctangent
// table (2^16 = 360 degrees, identical to the DDFS table), quadrant offsets.
package cordic_pkg;

  localparam int unsigned PHASE_BITS = 16;
  localparam int unsigned ATAN_LEN   = 16;

  // atan(2^-i) scaled so that 2^13 = 45 degrees
  localparam logic [PHASE_BITS-1:0] ATAN_TABLE [ATAN_LEN] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  localparam logic [PHASE_BITS-1:0] PHASE_Q0 = 16'd0;
  localparam logic [PHASE_BITS-1:0] PHASE_Q1 = 16'd16384;
  localparam logic [PHASE_BITS-1:0] PHASE_Q2 = 16'd32768;
  localparam logic [PHASE_BITS-1:0] PHASE_Q3 = 16'd49152;

  // Magnitude gain of the uncompensated iteration chain
  localparam real CORDIC_GAIN = 1.647;

  // Pre-rotation cases that bring the vector into the right half-plane
  typedef enum logic [1:0] {
    QUAD_RIGHT,
    QUAD_UPPER_LEFT,
    QUAD_LOWER_LEFT
  } prerot_e;

endpackage

// File: rtl/cordic_vector_stage.sv
// One registered vectoring-mode CORDIC iteration: rotates towards Y = 0 and
// accumulates the applied angle in Z.
module cordic_vector_stage
  import cordic_pkg::*;
#(
  parameter int unsigned           W     = 18,
  parameter int unsigned           SHIFT = 0,
  parameter logic [PHASE_BITS-1:0] ATAN  = '0
) (
  input  logic                         clock_100_MHz,
  input  logic                         clear_DDFS,
  input  logic signed [W-1:0]          x_in,
  input  logic signed [W-1:0]          y_in,
  input  logic        [PHASE_BITS-1:0] z_in,
  input  logic                         valid_in,
  input  logic                         zero_in,
  output logic signed [W-1:0]          x_out,
  output logic signed [W-1:0]          y_out,
  output logic        [PHASE_BITS-1:0] z_out,
  output logic                         valid_out,
  output logic                         zero_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  // Micro-rotation direction chosen by the sign of the stage-input Y
  always_ff @(posedge clock_100_MHz) begin
    if (clear_DDFS) begin
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      valid_out <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      if (!y_in[W-1]) begin
        x_out <= x_in + y_sh;
        y_out <= y_in - x_sh;
        z_out <= z_in + ATAN;
      end else begin
        x_out <= x_in - y_sh;
        y_out <= y_in + x_sh;
        z_out <= z_in - ATAN;
      end
      valid_out <= valid_in;
      zero_out  <= zero_in;
    end
  end

endmodule

// File: rtl/cordic_phase_detector.sv
// Pipelined vectoring CORDIC: I/Q in, phase/magnitude out, plus per-sample
// phase increment and a block-averaged increment.
module cordic_phase_detector
  import cordic_pkg::*;
#(
  parameter int unsigned SAN_CP   = 16,
  parameter int unsigned STG      = 16,
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic                  clock_100_MHz,
  input  logic                  clear_DDFS,
  input  logic [SAN_CP-1:0]     COSINE_IN,
  input  logic [SAN_CP-1:0]     SINE_IN,
  input  logic                  in_valid,
  output logic [PHASE_BITS-1:0] PHASE_OUT,
  output logic [SAN_CP+1:0]     MAG_OUT,
  output logic                  out_valid,
  output logic [PHASE_BITS-1:0] FREQ_OUT,
  output logic                  freq_valid,
  output logic [PHASE_BITS-1:0] FREQ_AVG,
  output logic                  avg_valid
);

  localparam int unsigned W  = SAN_CP + 2;
  localparam int unsigned SW = PHASE_BITS + AVG_LOG2;

  logic signed [W-1:0]          i_ext, q_ext, x_rot, y_rot;
  logic        [PHASE_BITS-1:0] z_rot;
  prerot_e                      quad;

  logic signed [W-1:0]          pre_x, pre_y;
  logic        [PHASE_BITS-1:0] pre_z;
  logic                         pre_valid, pre_zero;

  logic signed [W-1:0]          x_pipe    [STG+1];
  logic signed [W-1:0]          y_pipe    [STG+1];
  logic        [PHASE_BITS-1:0] z_pipe    [STG+1];
  logic                         v_pipe    [STG+1];
  logic                         zero_pipe [STG+1];

  logic [PHASE_BITS-1:0] prev_phase, phase_fin, freq_next;
  logic [W-1:0]          mag_fin;
  logic [SW-1:0]         freq_sum, sum_next;
  logic [AVG_LOG2-1:0]   avg_count;
  logic                  primed;

  // Select the quadrant fold that leaves X non-negative
  always_comb begin
    i_ext = {{2{COSINE_IN[SAN_CP-1]}}, COSINE_IN};
    q_ext = {{2{SINE_IN[SAN_CP-1]}}, SINE_IN};
    quad  = QUAD_RIGHT;
    if (i_ext[W-1]) quad = q_ext[W-1] ? QUAD_LOWER_LEFT : QUAD_UPPER_LEFT;
    x_rot = i_ext;
    y_rot = q_ext;
    z_rot = PHASE_Q0;
    case (quad)
      QUAD_UPPER_LEFT: begin x_rot = q_ext;  y_rot = -i_ext; z_rot = PHASE_Q1; end
      QUAD_LOWER_LEFT: begin x_rot = -q_ext; y_rot = i_ext;  z_rot = PHASE_Q3; end
      default: ;
    endcase
  end

  // Pre-rotation register; zero input is flagged here and carried along
  always_ff @(posedge clock_100_MHz) begin
    if (clear_DDFS) begin
      pre_x     <= '0;
      pre_y     <= '0;
      pre_z     <= '0;
      pre_valid <= 1'b0;
      pre_zero  <= 1'b0;
    end else begin
      pre_x     <= x_rot;
      pre_y     <= y_rot;
      pre_z     <= z_rot;
      pre_valid <= in_valid;
      pre_zero  <= (COSINE_IN == '0) && (SINE_IN == '0);
    end
  end

  assign x_pipe[0]    = pre_x;
  assign y_pipe[0]    = pre_y;
  assign z_pipe[0]    = pre_z;
  assign v_pipe[0]    = pre_valid;
  assign zero_pipe[0] = pre_zero;

  for (genvar g = 0; g < STG; g++) begin : g_stage
    cordic_vector_stage #(
      .W     (W),
      .SHIFT (g),
      .ATAN  (ATAN_TABLE[g])
    ) u_stage (
      .clock_100_MHz (clock_100_MHz),
      .clear_DDFS    (clear_DDFS),
      .x_in          (x_pipe[g]),
      .y_in          (y_pipe[g]),
      .z_in          (z_pipe[g]),
      .valid_in      (v_pipe[g]),
      .zero_in       (zero_pipe[g]),
      .x_out         (x_pipe[g+1]),
      .y_out         (y_pipe[g+1]),
      .z_out         (z_pipe[g+1]),
      .valid_out     (v_pipe[g+1]),
      .zero_out      (zero_pipe[g+1])
    );
  end

  assign phase_fin = zero_pipe[STG] ? '0 : z_pipe[STG];
  assign mag_fin   = zero_pipe[STG] ? '0 : x_pipe[STG];
  assign freq_next = phase_fin - prev_phase;
  assign sum_next  = freq_sum + {{AVG_LOG2{freq_next[PHASE_BITS-1]}}, freq_next};

  // Output register with phase differencing and block averaging; the mean is
  // the top 16 bits of the sign-extended sum, i.e. a floor arithmetic shift
  always_ff @(posedge clock_100_MHz) begin
    if (clear_DDFS) begin
      PHASE_OUT  <= '0;
      MAG_OUT    <= '0;
      FREQ_OUT   <= '0;
      FREQ_AVG   <= '0;
      out_valid  <= 1'b0;
      freq_valid <= 1'b0;
      avg_valid  <= 1'b0;
      prev_phase <= '0;
      freq_sum   <= '0;
      avg_count  <= '0;
      primed     <= 1'b0;
    end else begin
      out_valid  <= v_pipe[STG];
      freq_valid <= 1'b0;
      avg_valid  <= 1'b0;
      if (v_pipe[STG]) begin
        PHASE_OUT  <= phase_fin;
        MAG_OUT    <= mag_fin;
        prev_phase <= phase_fin;
        if (!primed) begin
          primed <= 1'b1;
        end else begin
          freq_valid <= 1'b1;
          FREQ_OUT   <= freq_next;
          if (avg_count == '1) begin
            FREQ_AVG  <= sum_next[AVG_LOG2 +: PHASE_BITS];
            avg_valid <= 1'b1;
            freq_sum  <= '0;
            avg_count <= '0;
          end else begin
            freq_sum  <= sum_next;
            avg_count <= avg_count + AVG_LOG2'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_detector.sv
// Randomised and directed bench for cordic_phase_detector against an
// atan2/sqrt reference model with cycle-exact valid alignment.
module tb_cordic_phase_detector;

  localparam int unsigned SAN_CP   = 16;
  localparam int unsigned STG      = 16;
  localparam int unsigned AVG_LOG2 = 4;
  localparam int  LAT  = STG + 2;
  localparam int  MAXC = 512;
  localparam real PI   = 3.14159265358979;
  localparam real GAIN = 1.6468;

  logic               clock_100_MHz = 1'b0;
  logic               clear_DDFS = 1'b0;
  logic               in_valid = 1'b0;
  logic [SAN_CP-1:0]  COSINE_IN = '0;
  logic [SAN_CP-1:0]  SINE_IN = '0;
  logic [15:0]        PHASE_OUT, FREQ_OUT, FREQ_AVG;
  logic [SAN_CP+1:0]  MAG_OUT;
  logic               out_valid, freq_valid, avg_valid;

  int n_cmp = 0;
  int n_err = 0;

  int  stim_i [MAXC];
  int  stim_q [MAXC];
  bit  stim_v [MAXC];
  bit  stim_c [MAXC];
  bit  cap_ov [MAXC], cap_fv [MAXC], cap_av [MAXC];
  int  cap_phase [MAXC], cap_mag [MAXC], cap_freq [MAXC], cap_avg [MAXC];
  bit  exp_ov [MAXC], exp_fv [MAXC], exp_av [MAXC], exp_zero [MAXC];
  int  exp_phase [MAXC], exp_freq [MAXC], exp_avg [MAXC];
  real exp_mag [MAXC];

  cordic_phase_detector #(
    .SAN_CP   (SAN_CP),
    .STG      (STG),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clock_100_MHz (clock_100_MHz),
    .clear_DDFS    (clear_DDFS),
    .COSINE_IN     (COSINE_IN),
    .SINE_IN       (SINE_IN),
    .in_valid      (in_valid),
    .PHASE_OUT     (PHASE_OUT),
    .MAG_OUT       (MAG_OUT),
    .out_valid     (out_valid),
    .FREQ_OUT      (FREQ_OUT),
    .freq_valid    (freq_valid),
    .FREQ_AVG      (FREQ_AVG),
    .avg_valid     (avg_valid)
  );

  always #5 clock_100_MHz = ~clock_100_MHz;

  function automatic int wrap16(input int d);
    int r;
    r = d & 32'hFFFF;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic int ideal_phase(input int i, input int q);
    real a;
    int  p;
    if (i == 0 && q == 0) return 0;
    a = $atan2(real'(q), real'(i)) * 65536.0 / (2.0 * PI);
    p = int'(a);
    if (p < 0) p += 65536;
    if (p >= 65536) p -= 65536;
    return p;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      stim_i[k] = 0; stim_q[k] = 0; stim_v[k] = 1'b0; stim_c[k] = 1'b0;
    end
  endtask

  task automatic add_phasor(input int first, input int count, input int spacing,
                            input int phase0, input int dphase);
    real ang;
    for (int j = 0; j < count; j++) begin
      ang = real'(phase0 + j * dphase) * 2.0 * PI / 65536.0;
      stim_i[first + j * spacing] = int'(16000.0 * $cos(ang));
      stim_q[first + j * spacing] = int'(16000.0 * $sin(ang));
      stim_v[first + j * spacing] = 1'b1;
    end
  endtask

  // Reference: each accepted sample appears LAT cycles later unless a clear
  // lands anywhere between its acceptance and its output edge.
  task automatic build_model(input int n);
    bit primed = 1'b0;
    int prev = 0, sum = 0, cnt = 0, k, ph, f;
    bit killed;
    for (int m = 0; m < MAXC; m++) begin
      exp_ov[m] = 0; exp_fv[m] = 0; exp_av[m] = 0; exp_zero[m] = 0;
      exp_phase[m] = 0; exp_freq[m] = 0; exp_avg[m] = 0; exp_mag[m] = 0.0;
    end
    for (int e = 0; e + 1 < n; e++) begin
      if (stim_c[e]) begin
        primed = 1'b0; prev = 0; sum = 0; cnt = 0;
        continue;
      end
      k = e - (LAT - 1);
      if (k < 0 || !stim_v[k]) continue;
      killed = 1'b0;
      for (int j = k; j <= e; j++) if (stim_c[j]) killed = 1'b1;
      if (killed) continue;
      ph = ideal_phase(stim_i[k], stim_q[k]);
      exp_ov[e+1]    = 1'b1;
      exp_phase[e+1] = ph;
      exp_zero[e+1]  = (stim_i[k] == 0 && stim_q[k] == 0);
      exp_mag[e+1]   = GAIN * $sqrt(real'(stim_i[k]) * real'(stim_i[k]) +
                                    real'(stim_q[k]) * real'(stim_q[k]));
      if (primed) begin
        f = wrap16(ph - prev);
        exp_fv[e+1] = 1'b1;
        exp_freq[e+1] = f;
        sum += f;
        if (cnt == (1 << AVG_LOG2) - 1) begin
          exp_av[e+1] = 1'b1;
          exp_avg[e+1] = sum >>> AVG_LOG2;
          sum = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
      primed = 1'b1;
      prev = ph;
    end
  endtask

  // Drive one step per cycle on the falling edge and record outputs seen there
  task automatic run(input int n);
    for (int m = 0; m < n; m++) begin
      @(negedge clock_100_MHz);
      cap_ov[m]    = out_valid;
      cap_fv[m]    = freq_valid;
      cap_av[m]    = avg_valid;
      cap_phase[m] = int'(PHASE_OUT);
      cap_mag[m]   = int'(MAG_OUT);
      cap_freq[m]  = wrap16(int'(FREQ_OUT));
      cap_avg[m]   = wrap16(int'(FREQ_AVG));
      clear_DDFS   = stim_c[m];
      in_valid     = stim_v[m];
      COSINE_IN    = 16'(stim_i[m]);
      SINE_IN      = 16'(stim_q[m]);
    end
  endtask

  task automatic test_reset();
    clear_DDFS = 1'b1; in_valid = 1'b1; COSINE_IN = 16'd1000; SINE_IN = 16'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_100_MHz);
      n_cmp++;
      if ({PHASE_OUT, MAG_OUT, FREQ_OUT, FREQ_AVG, out_valid, freq_valid, avg_valid} !== '0) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d: phase=%0d mag=%0d freq=%0d avg=%0d ov=%0b fv=%0b av=%0b, want all 0",
                 c, PHASE_OUT, MAG_OUT, FREQ_OUT, FREQ_AVG, out_valid, freq_valid, avg_valid);
      end
    end
    clear_DDFS = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clock_100_MHz);
      n_cmp++;
      if ({PHASE_OUT, MAG_OUT, FREQ_OUT, FREQ_AVG, out_valid, freq_valid, avg_valid} !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: phase=%0d mag=%0d ov=%0b fv=%0b av=%0b, want all 0",
                 c, PHASE_OUT, MAG_OUT, out_valid, freq_valid, avg_valid);
      end
    end
  endtask

  task automatic test_points();
    int pts_i [7] = '{1000, 0, -1000, 0, -32768, 0, 23170};
    int pts_q [7] = '{0, 1000, 0, -1000, 0, 0, 23170};
    int step, n, ri, rq;
    real tol;
    clear_stim();
    stim_c[0] = 1'b1;
    step = 2;
    for (int p = 0; p < 7; p++) begin
      stim_i[step] = pts_i[p]; stim_q[step] = pts_q[p]; stim_v[step] = 1'b1; step++;
    end
    for (int r = 0; r < 30; r++) begin
      do begin
        ri = int'($urandom_range(65535)) - 32768;
        rq = int'($urandom_range(65535)) - 32768;
      end while (real'(ri) * real'(ri) + real'(rq) * real'(rq) < 1048576.0);
      stim_i[step] = ri; stim_q[step] = rq;
      stim_v[step] = ($urandom_range(9) < 7);
      step++;
    end
    n = step + LAT + 4;
    build_model(n);
    run(n);
    for (int m = 0; m < n; m++) begin
      n_cmp++;
      if (cap_ov[m] !== exp_ov[m]) begin
        n_err++;
        $display("FAIL points_out_valid step %0d: got %0b want %0b", m, cap_ov[m], exp_ov[m]);
      end else if (exp_ov[m]) begin
        n_cmp++;
        if (absi(wrap16(cap_phase[m] - exp_phase[m])) > (exp_zero[m] ? 0 : 16)) begin
          n_err++;
          $display("FAIL points_phase step %0d: got %0d want %0d", m, cap_phase[m], exp_phase[m]);
        end
        tol = exp_zero[m] ? 0.0 : 0.005 * exp_mag[m] + 1.0;
        n_cmp++;
        if (absr(real'(cap_mag[m]) - exp_mag[m]) > tol) begin
          n_err++;
          $display("FAIL points_mag step %0d: got %0d want %0f", m, cap_mag[m], exp_mag[m]);
        end
      end
    end
  endtask

  task automatic test_freq(input int dphase, input int spacing);
    int n;
    clear_stim();
    stim_c[0] = 1'b1;
    add_phasor(1, 40, spacing, 60000, dphase);
    n = 1 + 40 * spacing + LAT + 4;
    build_model(n);
    run(n);
    for (int m = 0; m < n; m++) begin
      n_cmp++;
      if ({cap_ov[m], cap_fv[m], cap_av[m]} !== {exp_ov[m], exp_fv[m], exp_av[m]}) begin
        n_err++;
        $display("FAIL freq_valids d=%0d sp=%0d step %0d: got ov/fv/av=%0b%0b%0b want %0b%0b%0b",
                 dphase, spacing, m, cap_ov[m], cap_fv[m], cap_av[m], exp_ov[m], exp_fv[m], exp_av[m]);
      end
      if (exp_fv[m] && cap_fv[m]) begin
        n_cmp++;
        if (absi(cap_freq[m] - exp_freq[m]) > 16 || absi(cap_freq[m] - dphase) > 16) begin
          n_err++;
          $display("FAIL freq_out d=%0d sp=%0d step %0d: got %0d want %0d", dphase, spacing, m, cap_freq[m], exp_freq[m]);
        end
      end
      if (exp_av[m] && cap_av[m]) begin
        n_cmp++;
        if (absi(cap_avg[m] - exp_avg[m]) > 16 || absi(cap_avg[m] - dphase) > 16) begin
          n_err++;
          $display("FAIL freq_avg d=%0d sp=%0d step %0d: got %0d want %0d", dphase, spacing, m, cap_avg[m], exp_avg[m]);
        end
      end
    end
  endtask

  task automatic test_clear_mid_stream();
    int n, n_ov_flushed;
    clear_stim();
    stim_c[0] = 1'b1;
    add_phasor(1, 20, 1, 1000, 4096);
    stim_c[28] = 1'b1;
    stim_v[28] = 1'b1; stim_i[28] = 5000; stim_q[28] = 0;
    add_phasor(30, 20, 1, 30000, 4096);
    n = 50 + LAT + 4;
    build_model(n);
    run(n);
    n_ov_flushed = 0;
    for (int m = 29; m < 30 + LAT; m++) if (cap_ov[m]) n_ov_flushed++;
    n_cmp++;
    if (n_ov_flushed !== 0) begin
      n_err++;
      $display("FAIL clear_flush: got %0d out_valid after clear, want 0", n_ov_flushed);
    end
    for (int m = 0; m < n; m++) begin
      n_cmp++;
      if ({cap_ov[m], cap_fv[m], cap_av[m]} !== {exp_ov[m], exp_fv[m], exp_av[m]}) begin
        n_err++;
        $display("FAIL clear_valids step %0d: got ov/fv/av=%0b%0b%0b want %0b%0b%0b",
                 m, cap_ov[m], cap_fv[m], cap_av[m], exp_ov[m], exp_fv[m], exp_av[m]);
      end
      if (exp_av[m] && cap_av[m]) begin
        n_cmp++;
        if (absi(cap_avg[m] - exp_avg[m]) > 16) begin
          n_err++;
          $display("FAIL clear_avg step %0d: got %0d want %0d", m, cap_avg[m], exp_avg[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_points();
    test_freq(4096, 1);
    test_freq(-4096, 1);
    test_freq(4096, 3);
    test_clear_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
